// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Branch redirects beat stalls; jr redirects yield to stalls. Every redirect flushes IF/ID to a bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_reg_data,
  input  logic [31:0] jr_fwd_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam logic [1:0] JUMP_REG = 2'b01;
  localparam logic [1:0] JUMP_FWD = 2'b10;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jr_tgt;
  logic        jr_take;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign br_tgt    = branch_target & WORD_MASK;
  assign jr_tgt    = ((jump == JUMP_FWD) ? jr_fwd_data : jr_reg_data) & WORD_MASK;
  // Code 11 is reserved and falls through to sequential fetch.
  assign jr_take   = (jump == JUMP_REG) || (jump == JUMP_FWD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      // Older instruction's branch wins even over a stall or a younger jr.
      pc          <= br_tgt;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      if_id_instr <= if_id_instr;
      if_id_pc4   <= if_id_pc4;
      if_id_valid <= if_id_valid;
    end else if (jr_take) begin
      // No delay slot: the word fetched behind the jr is discarded.
      pc          <= jr_tgt;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      if_id_instr <= imem_rdata;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] jr_reg_data = 32'd0;
  logic [31:0] jr_fwd_data = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  always #5 clk = ~clk;

  // Memory image: word at address k is k ^ A5A5_0000.
  assign imem_rdata = imem_addr ^ MEM_KEY;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jr_reg_data(jr_reg_data), .jr_fwd_data(jr_fwd_data),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the architectural view of the fetch stage.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic flush_model(input logic [31:0] target);
    m_pc = target & 32'hFFFF_FFFC;
    m_instr = 32'd0;
    m_pc4 = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic rn, input logic st, input logic bt, input logic [31:0] btgt,
                      input logic [1:0] j, input logic [31:0] jreg, input logic [31:0] jfwd);
    exp_t e;
    @(negedge clk);
    reset_n = rn; stall = st; branch_taken = bt; branch_target = btgt;
    jump = j; jr_reg_data = jreg; jr_fwd_data = jfwd;
    if (!rn) begin
      m_pc = RESET_PC; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (bt) begin
      flush_model(btgt);
    end else if (st) begin
      // frozen
    end else if (j == 2'd1) begin
      flush_model(jreg);
    end else if (j == 2'd2) begin
      flush_model(jfwd);
    end else begin
      m_instr = m_pc ^ MEM_KEY;
      m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    exp_q.push_back(e);
  endtask

  task automatic clean();
    step(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
  endtask

  // Monitor: registered outputs settle after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("imem_addr", imem_addr, e.pc);
        check("if_id_instr", if_id_instr, e.instr);
        check("if_id_pc4", if_id_pc4, e.pc4);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h44, 2'b01, 32'd0, 32'd0);
    repeat (4) clean();
    // pc is now 0x10
    step(1'b1, 1'b0, 1'b1, 32'h43, 2'b00, 32'd0, 32'd0);
    repeat (2) clean();
    step(1'b1, 1'b0, 1'b0, 32'd0, 2'b01, 32'h200, 32'h300);
    repeat (2) clean();
    step(1'b1, 1'b0, 1'b0, 32'd0, 2'b10, 32'h200, 32'h300);
    repeat (2) clean();
    step(1'b1, 1'b0, 1'b0, 32'd0, 2'b11, 32'h200, 32'h300);
    clean();
    step(1'b1, 1'b0, 1'b1, 32'h1C, 2'b00, 32'd0, 32'd0);
    clean();
    // pc is now 0x20 with a valid word in IF/ID
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 2'b01, 32'h200, 32'h300);
    step(1'b1, 1'b1, 1'b1, 32'h80, 2'b00, 32'd0, 32'd0);
    repeat (2) clean();
    step(1'b1, 1'b0, 1'b1, 32'h100, 2'b10, 32'h200, 32'h300);
    repeat (2) clean();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, 32'd0, 32'd0);
    repeat (2) clean();
    step(1'b0, 1'b1, 1'b1, 32'h80, 2'b10, 32'h200, 32'h300);
    repeat (2) clean();

    for (int i = 0; i < 2000; i++) begin
      logic rn, st, bt;
      logic [1:0] j;
      rn = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(rn, st, bt, $urandom, j, $urandom, $urandom);
    end

    @(negedge clk);
    reset_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 2'b00;
    repeat (5) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode-stage control unit. Holds the PC, presents it to a combinational instruction memory and latches the returned instruction plus PC+4 into IF/ID for decode. Redirects the PC on taken branches from EX and on the 2-bit `jump` code the control unit produces for `jr`. Supports hazard stalls and bubble injection.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `stall`  in  1  hazard-unit request: hold PC and IF/ID
- `branch_taken`  in  1  EX-stage branch resolved taken
- `branch_target`  in  32  EX-stage branch target address
- `jump`  in  2  from control: 00 none, 01 jr using register-file value, 10 jr using forwarded value, 11 reserved
- `jr_reg_data`  in  32  rs value read from register file
- `jr_fwd_data`  in  32  rs value forwarded from the previous instruction's result
- `imem_addr`  out  32  instruction memory address (equals `pc`)
- `imem_rdata`  in  32  instruction word, combinational from `imem_addr`
- `pc`  out  32  current PC
- `if_id_instr`  out  32  latched instruction for decode
- `if_id_pc4`  out  32  latched PC+4 of that instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Reset (`reset_n`=0 at edge): `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0. Reset overrides every other input.
- Next-PC priority per edge (highest first):
  1. reset
  2. `branch_taken`: pc <= {branch_target[31:2],2'b00}
  3. `stall`: pc held
  4. `jump`=01: pc <= {jr_reg_data[31:2],2'b00}; `jump`=10: pc <= {jr_fwd_data[31:2],2'b00}
  5. otherwise pc <= pc+4
- IF/ID update per edge:
  - `branch_taken`: flush; instr <= 0 (NOP encoding), pc4 <= 0, valid <= 0. Flush applies even if `stall`=1.
  - else `stall`: all IF/ID fields held.
  - else `jump` 01/10: flush as above. No delay slot; the word fetched behind `jr` is discarded.
  - else: instr <= imem_rdata, pc4 <= pc+4, valid <= 1.
- `jump` is ignored while `stall`=1: the `jr` in decode is frozen and re-presents its code after the stall.
- `jump`=11 is treated as 00 (sequential fetch, no flush).
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000. Targets have bits [1:0] forced to 0; all other bits pass unchanged.
- No internal FSM beyond the PC and IF/ID registers. The decode stage must gate side effects with `if_id_valid`. An instruction word of 0 decodes as a harmless write to $0.

## Timing
- `imem_addr` = `pc` combinationally; `imem_rdata` is sampled at the same edge that advances `pc`.
- Fetch latency: the word at address A is presented when `pc`=A (cycle N) and appears on `if_id_instr` in cycle N+1.
- Branch redirect: `branch_taken` high in cycle N gives `pc`=target and `if_id_valid`=0 in N+1; the target instruction is valid in IF/ID in N+2 (one bubble from IF/ID; older EX/ID squashing is owned downstream).
- `jr` redirect: `jump`≠00 in cycle N gives `pc`=target and `if_id_valid`=0 in N+1; the target is in IF/ID in N+2.
- Stall: each stalled cycle holds `pc` and IF/ID exactly; normal fetch resumes on the first edge with `stall`=0.
- Branch and jump in the same cycle: branch wins (it belongs to the older instruction) and the `jr` is flushed.
- Reset asserted mid-stall or mid-redirect: the next edge yields the reset values, regardless of other inputs.
- All outputs are registered except `imem_addr`.

## Test plan
- Reset then sequential fetch: RESET_PC=0, memory word at address k = k ^ 32'hA5A5_0000, 4 clean cycles -> `if_id_instr` shows addresses 0,4,8,C in successive cycles with `if_id_pc4`=4,8,C,10 and `if_id_valid`=1 from the first post-reset edge+1.
- Taken branch: `pc`=0x10, `branch_taken`=1 with `branch_target`=0x43 -> next cycle `pc`=0x40 and `if_id_valid`=0; cycle after, `if_id_instr`=word@0x40 and `if_id_pc4`=0x44.
- Jump codes: `jump`=01 with `jr_reg_data`=0x200 and `jr_fwd_data`=0x300 -> `pc`=0x200 plus one bubble; repeat with `jump`=10 -> `pc`=0x300; `jump`=11 -> `pc`+4, no flush.
- Stall interactions: `stall`=1 for 3 cycles at `pc`=0x20 -> `pc` and IF/ID unchanged for 3 cycles; `stall`=1 with `jump`=01 -> jump ignored; `stall`=1 with `branch_taken`=1 (target 0x80) -> `pc`=0x80 and IF/ID flushed.
- Branch plus jump in the same cycle: `branch_taken`=1 (0x100) with `jump`=10 (0x300) -> `pc`=0x100 and `if_id_valid`=0.
- Wrap and reset mid-operation: `pc`=0xFFFF_FFFC with no redirect -> `pc`=0 and `if_id_pc4`=0; then `reset_n`=0 during `stall`=1 -> `pc`=RESET_PC, `if_id_instr`=0, `if_id_valid`=0 next cycle.
